// File: rtl/fp_sum_sequencer.sv
// fp_sum_sequencer: folds a valid/ready stream of FP exp() values into one sum through a shared pipelined adder.
// Latency: add_result sampled ADD_LAT cycles after the issuing cycle; backpressure: in_ready drops while the target lane awaits its add, sum_valid holds until sum_ready.
module fp_sum_sequencer #(
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count,
    output logic             busy
);
    localparam int LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        lane_q [ADD_LAT];
    logic [31:0]        lane_d [ADD_LAT];
    logic [ADD_LAT-1:0] lane_vld_q, lane_vld_d;
    logic [ADD_LAT-1:0] in_flight_q, in_flight_d;
    logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LW-1:0]      tag_lane_q [ADD_LAT];
    logic [LW-1:0]      tag_lane_d [ADD_LAT];
    logic [LW-1:0]      rr_q, rr_d;
    logic               in_ready_q, in_ready_d;
    logic               sum_valid_q, sum_valid_d;
    logic               busy_q, busy_d;
    logic [31:0]        sum_data_q, sum_data_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               issue;
    logic [LW-1:0]      issue_lane;
    logic [31:0]        rr_lane;
    logic               rr_lane_vld;
    logic               red_found;
    logic [31:0]        red_lane;
    logic [LW-1:0]      red_k;

    // Lane selected by rr, and the lowest-numbered filled lane above 0 for the fold.
    always_comb begin
        rr_lane     = '0;
        rr_lane_vld = 1'b0;
        red_found   = 1'b0;
        red_lane    = '0;
        red_k       = '0;
        for (int i = 0; i < ADD_LAT; i++) begin
            if (rr_q == LW'(i)) begin
                rr_lane     = lane_q[i];
                rr_lane_vld = lane_vld_q[i];
            end
        end
        for (int i = ADD_LAT - 1; i >= 1; i--) begin
            if (lane_vld_q[i]) begin
                red_found = 1'b1;
                red_lane  = lane_q[i];
                red_k     = LW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        lane_vld_d  = lane_vld_q;
        in_flight_d = in_flight_q;
        tag_vld_d   = '0;
        tag_lane_d  = tag_lane_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        sum_valid_d = sum_valid_q;
        sum_data_d  = sum_data_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        issue       = 1'b0;
        issue_lane  = '0;
        accept      = in_valid && in_ready_q;

        if (tag_vld_q[ADD_LAT-1]) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                if (tag_lane_q[ADD_LAT-1] == LW'(i)) begin
                    lane_d[i]      = add_result;
                    in_flight_d[i] = 1'b0;
                end
            end
        end

        if (accept) begin
            cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
            if (rr_lane_vld) begin
                issue      = 1'b1;
                issue_lane = rr_q;
                add_a_d    = rr_lane;
                add_b_d    = in_data;
            end
            for (int i = 0; i < ADD_LAT; i++) begin
                if (rr_q == LW'(i)) begin
                    if (rr_lane_vld) begin
                        in_flight_d[i] = 1'b1;
                    end else begin
                        lane_d[i]     = in_data;
                        lane_vld_d[i] = 1'b1;
                    end
                end
            end
            rr_d    = (rr_q == LW'(ADD_LAT - 1)) ? '0 : rr_q + 1'b1;
            state_d = in_last ? DRAIN : ACCUM;
        end

        case (state_q)
            DRAIN: begin
                if (tag_vld_q == '0) state_d = REDUCE;
            end
            REDUCE: begin
                // One fold at a time: lane 0 must hold the previous result before it is reused.
                if (tag_vld_q == '0) begin
                    if (red_found) begin
                        issue          = 1'b1;
                        issue_lane     = '0;
                        add_a_d        = lane_q[0];
                        add_b_d        = red_lane;
                        in_flight_d[0] = 1'b1;
                        for (int i = 1; i < ADD_LAT; i++) begin
                            if (red_k == LW'(i)) lane_vld_d[i] = 1'b0;
                        end
                    end else begin
                        state_d     = DONE;
                        sum_valid_d = 1'b1;
                        sum_data_d  = lane_q[0];
                    end
                end
            end
            DONE: begin
                if (sum_ready) begin
                    sum_valid_d = 1'b0;
                    lane_vld_d  = '0;
                    rr_d        = '0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        tag_vld_d[0]  = issue;
        tag_lane_d[0] = issue_lane;
        for (int i = 1; i < ADD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_lane_d[i] = tag_lane_q[i-1];
        end

        in_ready_d = 1'b0;
        if (state_d == IDLE) begin
            in_ready_d = 1'b1;
        end else if (state_d == ACCUM) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                if (rr_d == LW'(i)) in_ready_d = !in_flight_d[i];
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            lane_vld_q  <= '0;
            in_flight_q <= '0;
            tag_vld_q   <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_data_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                lane_q[i]     <= '0;
                tag_lane_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lane_vld_q  <= lane_vld_d;
            in_flight_q <= in_flight_d;
            tag_vld_q   <= tag_vld_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
            sum_data_q  <= sum_data_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            for (int i = 0; i < ADD_LAT; i++) begin
                lane_q[i]     <= lane_d[i];
                tag_lane_q[i] <= tag_lane_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_count = cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// tb_fp_sum_sequencer: three sequencers (ADD_LAT 1, 3, 4) each driving a behavioural FP adder.
// Vectors use multiples of 0.25 so every partial sum is exact and independent of fold order.
module tb_fp_sum_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic [31:0] in_data    [3];
    logic        in_last    [3];
    logic [31:0] add_a      [3];
    logic [31:0] add_b      [3];
    logic [31:0] add_result [3];
    logic        sum_valid  [3];
    logic        sum_ready  [3];
    logic [31:0] sum_data   [3];
    logic [15:0] sum_count  [3];
    logic        busy       [3];

    int          checks = 0;
    int          errors = 0;
    int          adds   [3];
    logic [63:0] prev_pair [3];

    always #5 clock = ~clock;

    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] ha [8];
        logic [31:0] hb [8];
        always @(posedge clock) begin
            ha[0] <= add_a[g];
            hb[0] <= add_b[g];
            for (int i = 1; i < 8; i++) begin
                ha[i] <= ha[i-1];
                hb[i] <= hb[i-1];
            end
        end
        assign add_result[g] = (L == 1) ? fadd(add_a[g], add_b[g])
                                        : fadd(ha[(L >= 2) ? L - 2 : 0], hb[(L >= 2) ? L - 2 : 0]);

        fp_sum_sequencer #(.ADD_LAT(L), .CNT_W(16)) u_dut (
            .clock      (clock),
            .resetn     (resetn),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_data    (in_data[g]),
            .in_last    (in_last[g]),
            .add_a      (add_a[g]),
            .add_b      (add_b[g]),
            .add_result (add_result[g]),
            .sum_valid  (sum_valid[g]),
            .sum_ready  (sum_ready[g]),
            .sum_data   (sum_data[g]),
            .sum_count  (sum_count[g]),
            .busy       (busy[g])
        );
    end

    // Each new operand pair on the adder port is one issued add.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (resetn && ({add_a[k], add_b[k]} != prev_pair[k])) adds[k]++;
            prev_pair[k] = {add_a[k], add_b[k]};
        end
    end

    typedef struct {
        int               u;
        int               n;
        int               gmax;
        logic [15:0][31:0] d;
        logic [31:0]      exp_sum;
        int               exp_cnt;
        int               exp_adds;
        int               exp_stalls;
    } vec_t;

    function automatic vec_t mk(input int u, input int n, input int gmax,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] fill, input logic [31:0] exp_sum,
                                input int exp_cnt, input int exp_adds, input int exp_stalls);
        vec_t v;
        v.u = u; v.n = n; v.gmax = gmax;
        for (int i = 0; i < 16; i++)
            v.d[i] = (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : (i == 3) ? d3 : fill;
        v.exp_sum = exp_sum; v.exp_cnt = exp_cnt;
        v.exp_adds = exp_adds; v.exp_stalls = exp_stalls;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input int u, input string nm);
        check({nm, "_in_ready"},  64'(in_ready[u]),  64'd0);
        check({nm, "_sum_valid"}, 64'(sum_valid[u]), 64'd0);
        check({nm, "_sum_data"},  64'(sum_data[u]),  64'd0);
        check({nm, "_sum_count"}, 64'(sum_count[u]), 64'd0);
        check({nm, "_add_a"},     64'(add_a[u]),     64'd0);
        check({nm, "_add_b"},     64'(add_b[u]),     64'd0);
        check({nm, "_busy"},      64'(busy[u]),      64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int u, input logic [31:0] d, input logic last, output int stalls);
        int t = 0;
        in_valid[u] = 1'b1; in_data[u] = d; in_last[u] = last;
        while (!in_ready[u] && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check("accept_timeout", 64'(in_ready[u]), 64'd1);
        stalls = t;
        @(negedge clock);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic wait_sum(input int u, output logic ok);
        int t = 0;
        while (!sum_valid[u] && t < 1000) begin
            @(negedge clock);
            t++;
        end
        ok = sum_valid[u];
        check("sum_valid_arrives", 64'(ok), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int   a0, st, tot;
        logic ok;
        a0 = adds[v.u]; tot = 0;
        for (int i = 0; i < v.n; i++) begin
            if (v.gmax > 0) repeat ($urandom_range(0, v.gmax)) @(negedge clock);
            send(v.u, v.d[i], (i == v.n - 1), st);
            tot += st;
        end
        wait_sum(v.u, ok);
        if (ok) begin
            check({nm, "_sum_data"},  64'(sum_data[v.u]),  64'(v.exp_sum));
            check({nm, "_sum_count"}, 64'(sum_count[v.u]), 64'(v.exp_cnt));
            if (v.exp_adds >= 0)   check({nm, "_adds"},   64'(adds[v.u] - a0), 64'(v.exp_adds));
            if (v.exp_stalls >= 0) check({nm, "_stalls"}, 64'(tot), 64'(v.exp_stalls));
        end
        sum_ready[v.u] = 1'b1;
        @(negedge clock);
        sum_ready[v.u] = 1'b0;
        check({nm, "_sum_valid_drop"}, 64'(sum_valid[v.u]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        vec_t        rv;
        logic        ok, hold_ok, rdy_low;
        int          st;
        real         s;
        int          k;

        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_data[u] = '0; in_last[u] = 1'b0; sum_ready[u] = 1'b0;
            adds[u] = 0; prev_pair[u] = '0;
        end

        tbl[0] = mk(0, 4, 0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h0,
                    32'h41200000, 4, -1, -1);
        tbl[1] = mk(2, 4, 0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h0,
                    32'h41200000, 4, 3, 0);
        tbl[2] = mk(1, 7, 3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                    32'h40E00000, 7, -1, -1);
        tbl[3] = mk(1, 1, 0, 32'h40200000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h40200000, 1, 0, -1);
        tbl[4] = mk(0, 2, 0, 32'h3F000000, 32'h3E800000, 32'h0, 32'h0, 32'h0,
                    32'h3F400000, 2, 1, -1);
        tbl[5] = mk(2, 6, 1, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                    32'h41400000, 6, -1, -1);

        repeat (3) @(negedge clock);
        for (int u = 0; u < 3; u++) chk_reset(u, "reset");
        resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            check("idle_in_ready", 64'(in_ready[u]), 64'd1);
            check("idle_busy",     64'(busy[u]),     64'd0);
        end

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // DONE held with sum_ready low, then the next vector goes in right after release.
        send(0, 32'h40400000, 1'b0, st);
        send(0, 32'h3F800000, 1'b1, st);
        wait_sum(0, ok);
        hold_ok = 1'b1; rdy_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!sum_valid[0] || sum_data[0] != 32'h40800000) hold_ok = 1'b0;
            if (in_ready[0]) rdy_low = 1'b0;
            @(negedge clock);
        end
        check("hold_sum_data",  64'(sum_data[0]), 64'h40800000);
        check("hold_stable",    64'(hold_ok),     64'd1);
        check("hold_in_ready0", 64'(rdy_low),     64'd1);
        sum_ready[0] = 1'b1;
        @(negedge clock);
        sum_ready[0] = 1'b0;
        check("release_sum_valid", 64'(sum_valid[0]), 64'd0);
        check("release_in_ready",  64'(in_ready[0]),  64'd1);
        check("release_count_hold", 64'(sum_count[0]), 64'd2);
        send(0, 32'h3F800000, 1'b1, st);
        check("next_vec_no_stall", 64'(st), 64'd0);
        wait_sum(0, ok);
        check("next_vec_sum",   64'(sum_data[0]),  64'h3F800000);
        check("next_vec_count", 64'(sum_count[0]), 64'd1);
        sum_ready[0] = 1'b1;
        @(negedge clock);
        sum_ready[0] = 1'b0;

        // Randomised vectors against the plain-arithmetic sum.
        for (int r = 0; r < 9; r++) begin
            rv.u = r % 3; rv.n = $urandom_range(1, 12); rv.gmax = 2;
            rv.d = '0; s = 0.0;
            for (int i = 0; i < rv.n; i++) begin
                k = $urandom_range(1, 64);
                s += real'(k) * 0.25;
                rv.d[i] = r2sp(real'(k) * 0.25);
            end
            rv.exp_sum = r2sp(s); rv.exp_cnt = rv.n; rv.exp_adds = -1; rv.exp_stalls = -1;
            run_vec(rv, $sformatf("rand%0d", r));
        end

        // Reset mid-ACCUM with adds in flight on the ADD_LAT=4 instance.
        for (int i = 0; i < 6; i++) send(2, 32'h3F800000, 1'b0, st);
        check("pre_reset_busy", 64'(busy[2]), 64'd1);
        #1 resetn = 1'b0;
        #1 chk_reset(2, "midreset");
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        rv = mk(2, 2, 0, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'h0,
                32'h40000000, 2, 1, -1);
        run_vec(rv, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
